// File: rtl/lp2_box_solver.sv
// lp2_box_solver: two-variable integer LP solver that loads an objective and
// N_CONS rows, then scans the integer box [X_LO, X_HI]^2 at one candidate per
// cycle and reports the best feasible objective and its argument.
module lp2_box_solver #(
    parameter int unsigned N_CONS = 6,
    parameter int unsigned CW     = 6,
    parameter int unsigned BW     = 12,
    parameter int          X_LO   = -8,
    parameter int          X_HI   = 7,
    parameter int unsigned XW     = 5,
    localparam int unsigned OW    = CW + XW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_mode,
    input  logic signed [CW-1:0] in_a1,
    input  logic signed [CW-1:0] in_a2,
    input  logic signed [BW-1:0] in_b,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic                 out_feasible,
    output logic signed [OW-1:0] out_value,
    output logic signed [XW-1:0] out_x1,
    output logic signed [XW-1:0] out_x2
);

    localparam int unsigned CMPW = ((OW > BW) ? OW : BW) + 1;
    localparam int unsigned BCW  = $clog2(N_CONS + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_OUT} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic signed [CW-1:0]  c1_q, c1_d, c2_q, c2_d;
    logic signed [CW-1:0]  a1_q [N_CONS];
    logic signed [CW-1:0]  a1_d [N_CONS];
    logic signed [CW-1:0]  a2_q [N_CONS];
    logic signed [CW-1:0]  a2_d [N_CONS];
    logic signed [BW-1:0]  b_q  [N_CONS];
    logic signed [BW-1:0]  b_d  [N_CONS];
    logic [BCW-1:0]        beat_q, beat_d;
    logic signed [XW-1:0]  x1_q, x1_d, x2_q, x2_d;
    logic                  done_q, done_d;
    logic                  found_q, found_d;
    logic signed [OW-1:0]  best_val_q, best_val_d;
    logic signed [XW-1:0]  best_x1_q, best_x1_d, best_x2_q, best_x2_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_feasible_q, out_feasible_d;
    logic signed [OW-1:0]  out_value_q, out_value_d;
    logic signed [XW-1:0]  out_x1_q, out_x1_d, out_x2_q, out_x2_d;

    logic signed [OW-1:0]  row_sum_c [N_CONS];
    logic signed [OW-1:0]  obj_c;
    logic                  feas_c;
    logic                  better_c;

    // Evaluate the current candidate against every row and the objective
    always_comb begin
        feas_c = 1'b1;
        for (int i = 0; i < int'(N_CONS); i++) begin
            row_sum_c[i] = OW'(a1_q[i]) * OW'(x1_q) + OW'(a2_q[i]) * OW'(x2_q);
            if (!(CMPW'(row_sum_c[i]) <= CMPW'(b_q[i]))) begin
                feas_c = 1'b0;
            end
        end
        obj_c    = OW'(c1_q) * OW'(x1_q) + OW'(c2_q) * OW'(x2_q);
        better_c = mode_q ? (obj_c < best_val_q) : (obj_c > best_val_q);
    end

    // Next-state and datapath control
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        c1_d           = c1_q;
        c2_d           = c2_q;
        a1_d           = a1_q;
        a2_d           = a2_q;
        b_d            = b_q;
        beat_d         = beat_q;
        x1_d           = x1_q;
        x2_d           = x2_q;
        done_d         = done_q;
        found_d        = found_q;
        best_val_d     = best_val_q;
        best_x1_d      = best_x1_q;
        best_x2_d      = best_x2_q;
        out_valid_d    = 1'b0;
        out_feasible_d = 1'b0;
        out_value_d    = '0;
        out_x1_d       = '0;
        out_x2_d       = '0;

        case (state_q)
            S_IDLE, S_OUT: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    c1_d    = in_a1;
                    c2_d    = in_a2;
                    beat_d  = BCW'(1);
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (!in_valid) begin
                    state_d = S_IDLE;
                end else begin
                    for (int i = 0; i < int'(N_CONS); i++) begin
                        if (beat_q == BCW'(i + 1)) begin
                            a1_d[i] = in_a1;
                            a2_d[i] = in_a2;
                            b_d[i]  = in_b;
                        end
                    end
                    if (beat_q == BCW'(N_CONS)) begin
                        state_d    = S_SCAN;
                        x1_d       = XW'(X_LO);
                        x2_d       = XW'(X_LO);
                        done_d     = 1'b0;
                        found_d    = 1'b0;
                        best_val_d = '0;
                        best_x1_d  = '0;
                        best_x2_d  = '0;
                    end else begin
                        beat_d = beat_q + BCW'(1);
                    end
                end
            end
            S_SCAN: begin
                if (done_q) begin
                    state_d        = S_OUT;
                    out_valid_d    = 1'b1;
                    out_feasible_d = found_q;
                    out_value_d    = best_val_q;
                    out_x1_d       = best_x1_q;
                    out_x2_d       = best_x2_q;
                end else begin
                    if (feas_c && (!found_q || better_c)) begin
                        found_d    = 1'b1;
                        best_val_d = obj_c;
                        best_x1_d  = x1_q;
                        best_x2_d  = x2_q;
                    end
                    if (x1_q == XW'(X_HI)) begin
                        x1_d = XW'(X_LO);
                        if (x2_q == XW'(X_HI)) begin
                            done_d = 1'b1;
                        end else begin
                            x2_d = x2_q + XW'(1);
                        end
                    end else begin
                        x1_d = x1_q + XW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            mode_q         <= 1'b0;
            c1_q           <= '0;
            c2_q           <= '0;
            for (int i = 0; i < int'(N_CONS); i++) begin
                a1_q[i] <= '0;
                a2_q[i] <= '0;
                b_q[i]  <= '0;
            end
            beat_q         <= '0;
            x1_q           <= '0;
            x2_q           <= '0;
            done_q         <= 1'b0;
            found_q        <= 1'b0;
            best_val_q     <= '0;
            best_x1_q      <= '0;
            best_x2_q      <= '0;
            out_valid_q    <= 1'b0;
            out_feasible_q <= 1'b0;
            out_value_q    <= '0;
            out_x1_q       <= '0;
            out_x2_q       <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            c1_q           <= c1_d;
            c2_q           <= c2_d;
            a1_q           <= a1_d;
            a2_q           <= a2_d;
            b_q            <= b_d;
            beat_q         <= beat_d;
            x1_q           <= x1_d;
            x2_q           <= x2_d;
            done_q         <= done_d;
            found_q        <= found_d;
            best_val_q     <= best_val_d;
            best_x1_q      <= best_x1_d;
            best_x2_q      <= best_x2_d;
            out_valid_q    <= out_valid_d;
            out_feasible_q <= out_feasible_d;
            out_value_q    <= out_value_d;
            out_x1_q       <= out_x1_d;
            out_x2_q       <= out_x2_d;
        end
    end

    assign in_ready     = (state_q != S_SCAN);
    assign out_valid    = out_valid_q;
    assign out_feasible = out_feasible_q;
    assign out_value    = out_value_q;
    assign out_x1       = out_x1_q;
    assign out_x2       = out_x2_q;

endmodule
